// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Holds the arbiter state encoding, the grant encoding and a small helper
// used by the tie breaker.
package mem_arb_pkg;

  // Arbiter FSM states: idle/issue, then one wait state per requester.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  // Which requester owns the memory port.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // The grant that was not given last time.
  function automatic gnt_t otherGnt(input gnt_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Tie resolution between instruction fetch and data access requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only uses gnt while it is able to issue.
//
// Ports:
//   iReq, dReq : pending requests from fetch and data side
//   lastGnt    : grant of the previous issue (constant GNT_I in fixed mode)
//   gnt        : chosen requester
//
// A lone request always wins. On a tie the requester that did not win last
// time is chosen; with lastGnt held at GNT_I this reduces to data priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic iReq,
  input  logic dReq,
  input  gnt_t lastGnt,
  output gnt_t gnt
);

  always_comb begin
    gnt = GNT_I;
    if (iReq && dReq) begin
      gnt = otherGnt(lastGnt);
    end else if (dReq) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between fetch and data.
// Latency: 2 cycles per access (issue in N, ready strobe in N+1).
// Backpressure: requesters hold req until their ready strobe; issues are
//               spaced at least 2 cycles apart.
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   iReq/iAddr -> iRdata/iReady   : instruction fetch port
//   dReq/dWe/dAddr/dWdata
//                -> dRdata/dReady : data load/store port
//   mEn/mWe/mAddr/mWdata, mRdata  : RAM port (read data one cycle after issue)
//
// Build option: define MEM_ARB_RR_EN to resolve ties round-robin using a
// 1-bit last-grant register; otherwise ties go to data and no register is
// built.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iReq,
  input  logic [AW-1:0] iAddr,
  output logic [DW-1:0] iRdata,
  output logic          iReady,
  input  logic          dReq,
  input  logic          dWe,
  input  logic [AW-1:0] dAddr,
  input  logic [DW-1:0] dWdata,
  output logic [DW-1:0] dRdata,
  output logic          dReady,
  output logic          mEn,
  output logic          mWe,
  output logic [AW-1:0] mAddr,
  output logic [DW-1:0] mWdata,
  input  logic [DW-1:0] mRdata
);

  state_t state;
  state_t nextState;
  gnt_t   gnt;
  gnt_t   lastGnt;
  logic   anyReq;
  logic   issue;
  logic   dWeQ;   // remembers whether the data access in flight is a store

  assign anyReq = iReq || dReq;
  // An issue is suppressed during reset so nothing is started that could
  // later be acknowledged.
  assign issue  = (state == IDLE) && anyReq && !reset;

  arb_pick uPick (
    .iReq    (iReq),
    .dReq    (dReq),
    .lastGnt (lastGnt),
    .gnt     (gnt)
  );

`ifdef MEM_ARB_RR_EN
  // Starts at GNT_I so the first tie after reset goes to data.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGnt <= GNT_I;
    end else if (issue) begin
      lastGnt <= gnt;
    end
  end
`else
  assign lastGnt = GNT_I;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dWeQ <= 1'b0;
    end else if (issue && (gnt == GNT_D)) begin
      dWeQ <= dWe;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState = (gnt == GNT_D) ? D_WAIT : I_WAIT;
        end
      end
      I_WAIT:  nextState = IDLE;
      D_WAIT:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is high, which also
  // hides the ready strobe of an access aborted by reset.
  always_comb begin
    mEn    = 1'b0;
    mWe    = 1'b0;
    mAddr  = '0;
    mWdata = '0;
    iReady = 1'b0;
    iRdata = '0;
    dReady = 1'b0;
    dRdata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            mEn = 1'b1;
            if (gnt == GNT_D) begin
              mWe    = dWe;
              mAddr  = dAddr;
              mWdata = dWdata;
            end else begin
              mAddr  = iAddr;
            end
          end
        end
        I_WAIT: begin
          iReady = 1'b1;
          iRdata = mRdata;
        end
        D_WAIT: begin
          dReady = 1'b1;
          dRdata = dWeQ ? '0 : mRdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model (shadow memory, one
// outstanding access, tie rule).
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          mEn;
    logic          mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata;
    logic          iReady;
    logic [DW-1:0] iRdata;
    logic          dReady;
    logic [DW-1:0] dRdata;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iReq = 1'b0;
  logic [AW-1:0] iAddr = '0;
  logic [DW-1:0] iRdata;
  logic          iReady;
  logic          dReq = 1'b0;
  logic          dWe = 1'b0;
  logic [AW-1:0] dAddr = '0;
  logic [DW-1:0] dWdata = '0;
  logic [DW-1:0] dRdata;
  logic          dReady;
  logic          mEn;
  logic          mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata;
  logic [DW-1:0] mRdata = '0;

  int vecs = 0;
  int errs = 0;

  logic [DW-1:0] ram [256];
  logic [DW-1:0] shadow [256];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .iReq   (iReq),
    .iAddr  (iAddr),
    .iRdata (iRdata),
    .iReady (iReady),
    .dReq   (dReq),
    .dWe    (dWe),
    .dAddr  (dAddr),
    .dWdata (dWdata),
    .dRdata (dRdata),
    .dReady (dReady),
    .mEn    (mEn),
    .mWe    (mWe),
    .mAddr  (mAddr),
    .mWdata (mWdata),
    .mRdata (mRdata)
  );

  // Single-port synchronous RAM environment.
  always @(posedge clk) begin
    if (mEn) begin
      if (mWe) ram[mAddr[7:0]] <= mWdata;
      else     mRdata <= ram[mAddr[7:0]];
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o.mEn = mEn;       o.mWe = mWe;       o.mAddr = mAddr;   o.mWdata = mWdata;
    o.iReady = iReady; o.iRdata = iRdata; o.dReady = dReady; o.dRdata = dRdata;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t o;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      o = sample();
      vecs++;
      if (o !== e) begin errs++; $display("FAIL reset_hold: got %h want %h", o, e); end
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = sample();
      vecs++;
      if (o !== e) begin errs++; $display("FAIL reset_idle: got %h want %h", o, e); end
      if (c < 2) step();
    end
  endtask

  task automatic test_fetch();
    obs_t e;
    obs_t o;
    step();
    iReq = 1'b1; iAddr = 32'h4;
    @(negedge clk);
    e = '0; e.mEn = 1'b1; e.mAddr = 32'h4;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL fetch_issue: got %h want %h", o, e); end
    step();
    @(negedge clk);
    e = '0; e.iReady = 1'b1; e.iRdata = 32'h00108093;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL fetch_ready: got %h want %h", o, e); end
    step();
    iReq = 1'b0;
    @(negedge clk);
    e = '0;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL fetch_idle: got %h want %h", o, e); end
  endtask

  task automatic test_store_load();
    obs_t e;
    obs_t o;
    step();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h0; dWdata = 32'h01FE;
    @(negedge clk);
    e = '0; e.mEn = 1'b1; e.mWe = 1'b1; e.mAddr = 32'h0; e.mWdata = 32'h01FE;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL store_issue: got %h want %h", o, e); end
    shadow[0] = 32'h01FE;
    step();
    @(negedge clk);
    e = '0; e.dReady = 1'b1;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL store_ready: got %h want %h", o, e); end
    step();
    dWe = 1'b0; dWdata = '0;
    @(negedge clk);
    e = '0; e.mEn = 1'b1; e.mAddr = 32'h0;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL load_issue: got %h want %h", o, e); end
    step();
    @(negedge clk);
    e = '0; e.dReady = 1'b1; e.dRdata = 32'h01FE;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL load_ready: got %h want %h", o, e); end
    step();
    dReq = 1'b0;
    @(negedge clk);
    e = '0;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL load_idle: got %h want %h", o, e); end
  endtask

  task automatic test_tie();
    obs_t e;
    obs_t o;
    bit lastD;
    bit win;
    step();
    reset = 1'b1; iReq = 1'b0; dReq = 1'b0;
    step();
    step();
    reset = 1'b0;
    iReq = 1'b1; iAddr = 32'h8;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'hC; dWdata = '0;
    lastD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      win = RR ? !lastD : 1'b1;
      lastD = win;
      e = '0; e.mEn = 1'b1; e.mAddr = win ? 32'hC : 32'h8;
      o = sample(); vecs++;
      if (o !== e) begin errs++; $display("FAIL tie_issue%0d: got %h want %h", k, o, e); end
      step();
      @(negedge clk);
      e = '0;
      if (win) begin e.dReady = 1'b1; e.dRdata = shadow[12]; end
      else     begin e.iReady = 1'b1; e.iRdata = shadow[8]; end
      o = sample(); vecs++;
      if (o !== e) begin errs++; $display("FAIL tie_ready%0d: got %h want %h", k, o, e); end
      step();
    end
    dReq = 1'b0;
    @(negedge clk);
    e = '0; e.mEn = 1'b1; e.mAddr = 32'h8;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL tie_fetch_issue: got %h want %h", o, e); end
    step();
    @(negedge clk);
    e = '0; e.iReady = 1'b1; e.iRdata = shadow[8];
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL tie_fetch_ready: got %h want %h", o, e); end
    step();
    iReq = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t e;
    obs_t o;
    iReq = 1'b1; iAddr = 32'h4;
    @(negedge clk);
    e = '0; e.mEn = 1'b1; e.mAddr = 32'h4;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL abort_issue: got %h want %h", o, e); end
    step();
    reset = 1'b1;
    @(negedge clk);
    e = '0;
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL abort_no_ready: got %h want %h", o, e); end
    step();
    reset = 1'b0; iReq = 1'b0;
    @(negedge clk);
    o = sample(); vecs++;
    if (o !== e) begin errs++; $display("FAIL abort_idle: got %h want %h", o, e); end
  endtask

  task automatic test_random();
    obs_t e;
    obs_t o;
    bit iPend, dPend, iDone, dDone, dWeM;
    logic [7:0] iA, dA;
    logic [DW-1:0] dD;
    bit ov, ow, owe, lastD, win;
    logic [DW-1:0] oData;
    iPend = 0; dPend = 0; iDone = 0; dDone = 0; dWeM = 0;
    iA = '0; dA = '0; dD = '0;
    ov = 0; ow = 0; owe = 0; lastD = 0; oData = '0;
    step();
    reset = 1'b1; iReq = 1'b0; dReq = 1'b0;
    step();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      if (!iPend || iDone) begin
        iPend = ($urandom_range(0, 2) != 0);
        iA    = 8'($urandom_range(0, 255));
        iDone = 0;
      end
      if (!dPend || dDone) begin
        dPend = ($urandom_range(0, 2) != 0);
        dA    = 8'($urandom_range(0, 255));
        dWeM  = $urandom_range(0, 1) != 0;
        dD    = dWeM ? DW'($urandom) : '0;
        dDone = 0;
      end
      iReq = iPend; iAddr = AW'(iA);
      dReq = dPend; dWe = dWeM; dAddr = AW'(dA); dWdata = dD;
      @(negedge clk);
      e = '0;
      if (reset) begin
        ov = 0; lastD = 0;
      end else if (ov) begin
        if (ow) begin e.dReady = 1'b1; e.dRdata = owe ? '0 : oData; dDone = 1; end
        else    begin e.iReady = 1'b1; e.iRdata = oData; iDone = 1; end
        ov = 0;
      end else if (iPend || dPend) begin
        win = (iPend && dPend) ? (RR ? !lastD : 1'b1) : dPend;
        e.mEn = 1'b1;
        if (win) begin
          e.mWe = dWeM; e.mAddr = AW'(dA); e.mWdata = dD;
          oData = shadow[dA]; owe = dWeM;
          if (dWeM) shadow[dA] = dD;
        end else begin
          e.mAddr = AW'(iA);
          oData = shadow[iA]; owe = 0;
        end
        ov = 1; ow = win; lastD = win;
      end
      o = sample(); vecs++;
      if (o !== e) begin errs++; $display("FAIL random_cyc%0d: got %h want %h", n, o, e); end
      step();
    end
    reset = 1'b0; iReq = 1'b0; dReq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = (i == 4) ? 32'h00108093 : DW'($urandom);
      ram[i] <= v;
      shadow[i] = v;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
